// File: rtl/ram_access_ctrl_if.sv
// Bus bundle between the core requesters (IF, LS), the access controller
// and the single-port word-wide data RAM.
interface ram_access_ctrl_if #(
    parameter int ADDR_W = 16
);
    // instruction fetch port
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    // load/store port
    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;
    logic              ls_err;

    // RAM port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // controller view
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    // requester / RAM view
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Shares one synchronous single-port data RAM between instruction fetch and
// load/store. Round-robin on contention, fixed 1-cycle read latency, and
// sub-word stores turned into read-modify-write so the RAM only sees full
// word writes.
module ram_access_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_access_ctrl_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    // Replace the addressed byte or halfword lane of a word (little-endian).
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [15:0] data,
        input logic        half,
        input logic [1:0]  lane
    );
        logic [31:0] w;
        w = old_word;
        if (half) begin
            if (lane[1]) begin
                w[31:16] = data;
            end else begin
                w[15:0] = data;
            end
        end else begin
            case (lane)
                2'd0:    w[7:0]   = data[7:0];
                2'd1:    w[15:8]  = data[7:0];
                2'd2:    w[23:16] = data[7:0];
                2'd3:    w[31:24] = data[7:0];
                default: w = old_word;
            endcase
        end
        return w;
    endfunction

    // Misaligned halfword/word or the reserved size code.
    function automatic logic ls_bad_access(
        input logic [1:0] size,
        input logic [1:0] low_addr
    );
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = low_addr[0];
            2'b10:   bad = (low_addr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    state_t             state_r;
    logic               last_ls_r;      // 1: LS was granted most recently
    logic               if_rvalid_r;
    logic               ls_rvalid_r;
    logic [31:0]        if_rdata_r;
    logic [31:0]        ls_rdata_r;
    logic [ADDR_W-1:0]  mrg_addr_r;
    logic [1:0]         mrg_lane_r;
    logic               mrg_half_r;
    logic [15:0]        mrg_data_r;

    logic               if_gnt_s;
    logic               ls_gnt_s;
    logic               ls_err_s;
    logic               ls_rd_s;        // LS load accepted
    logic               ls_rmw_s;       // LS sub-word store accepted
    logic               pick_ls_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic               mem_we_s;
    logic [31:0]        mem_wdata_s;

    // Upper address bits alias by design; upper store data is not used.
    logic               unused_s;
    assign unused_s = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                        bus.ls_addr[31:ADDR_W+2], bus.ls_wdata[31:16]};

    // Arbitration, grant decode and RAM port drive for the current cycle.
    always_comb begin
        if_gnt_s    = 1'b0;
        ls_gnt_s    = 1'b0;
        ls_err_s    = 1'b0;
        ls_rd_s     = 1'b0;
        ls_rmw_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_wdata_s = 32'h0000_0000;
        mem_addr_s  = bus.if_addr[ADDR_W+1:2];
        pick_ls_s   = bus.ls_req & (~bus.if_req | ~last_ls_r);
        if (!rst) begin
            pick_ls_s = 1'b0;
        end else if (state_r == ST_MERGE) begin
            // second half of read-modify-write: commit merged word
            mem_addr_s  = mrg_addr_r;
            mem_we_s    = 1'b1;
            mem_wdata_s = merge_lanes(bus.mem_rdata, mrg_data_r, mrg_half_r, mrg_lane_r);
        end else if (pick_ls_s) begin
            ls_gnt_s = 1'b1;
            if (ls_bad_access(bus.ls_size, bus.ls_addr[1:0])) begin
                ls_err_s = 1'b1;
            end else begin
                mem_addr_s = bus.ls_addr[ADDR_W+1:2];
                if (!bus.ls_we) begin
                    ls_rd_s = 1'b1;
                end else if (bus.ls_size == 2'b10) begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = bus.ls_wdata;
                end else begin
                    ls_rmw_s = 1'b1;
                end
            end
        end else if (bus.if_req) begin
            if_gnt_s   = 1'b1;
            mem_addr_s = bus.if_addr[ADDR_W+1:2];
        end else begin
            if_gnt_s = 1'b0;
        end
    end

    // Controller state: FSM, round-robin pointer, read return and RMW latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            last_ls_r   <= 1'b0;
            if_rvalid_r <= 1'b0;
            ls_rvalid_r <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            ls_rdata_r  <= 32'h0000_0000;
            mrg_addr_r  <= '0;
            mrg_lane_r  <= 2'b00;
            mrg_half_r  <= 1'b0;
            mrg_data_r  <= 16'h0000;
        end else begin
            if_rvalid_r <= if_gnt_s;
            ls_rvalid_r <= ls_rd_s;
            if (if_rvalid_r) begin
                if_rdata_r <= bus.mem_rdata;
            end
            if (ls_rvalid_r) begin
                ls_rdata_r <= bus.mem_rdata;
            end
            if (if_gnt_s | ls_gnt_s) begin
                last_ls_r <= ls_gnt_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (ls_rmw_s) begin
                        state_r    <= ST_MERGE;
                        mrg_addr_r <= bus.ls_addr[ADDR_W+1:2];
                        mrg_lane_r <= bus.ls_addr[1:0];
                        mrg_half_r <= (bus.ls_size == 2'b01);
                        mrg_data_r <= bus.ls_wdata[15:0];
                    end
                end
                ST_MERGE: state_r <= ST_IDLE;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    // Read data follows the RAM in the valid cycle and holds afterwards.
    assign bus.if_gnt    = if_gnt_s;
    assign bus.ls_gnt    = ls_gnt_s;
    assign bus.ls_err    = ls_err_s;
    assign bus.if_rvalid = if_rvalid_r;
    assign bus.ls_rvalid = ls_rvalid_r;
    assign bus.if_rdata  = if_rvalid_r ? bus.mem_rdata : if_rdata_r;
    assign bus.ls_rdata  = ls_rvalid_r ? bus.mem_rdata : ls_rdata_r;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural RAM, scoreboard queues for read
// returns, a table of load/store vectors and hand-written corner sequences.
module tb_ram_access_ctrl;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    ram_access_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // behavioural RAM with a backdoor preload port
    logic [31:0] ram [0:255];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] if_q [$];
    logic [31:0] ls_q [$];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.sz = sz; v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
        tbl.push_back(v);
    endtask

    // Issue one LS request, wait (bounded) for grant, check error, score loads.
    task automatic ls_op(input vec_t v);
        logic got;
        bus.ls_req   = 1'b1;
        bus.ls_we    = v.we;
        bus.ls_size  = v.sz;
        bus.ls_addr  = v.addr;
        bus.ls_wdata = v.wdata;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bus.ls_gnt;
            if (!got) @(posedge clk);
        end
        chk("ls_gnt_wait", {31'b0, got}, 32'd1);
        if (got) begin
            chk("ls_err", {31'b0, bus.ls_err}, {31'b0, v.err});
            if (!v.we && !v.err) ls_q.push_back(v.rdata);
        end
        tick();
        bus.ls_req = 1'b0;
    endtask

    // Scoreboard / protocol monitor sampled on the falling edge.
    logic prev_if_gnt, prev_ls_rd;
    always @(negedge clk) begin
        if (!rst) begin
            prev_if_gnt = 1'b0;
            prev_ls_rd  = 1'b0;
        end else begin
            if (prev_if_gnt || bus.if_rvalid)
                chk("if_rvalid_timing", {31'b0, bus.if_rvalid}, {31'b0, prev_if_gnt});
            if (prev_ls_rd || bus.ls_rvalid)
                chk("ls_rvalid_timing", {31'b0, bus.ls_rvalid}, {31'b0, prev_ls_rd});
            if (bus.if_rvalid) begin
                if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
                else chk("if_rdata", bus.if_rdata, if_q.pop_front());
            end
            if (bus.ls_rvalid) begin
                if (ls_q.size() == 0) chk("ls_rvalid_unexpected", 32'd1, 32'd0);
                else chk("ls_rdata", bus.ls_rdata, ls_q.pop_front());
            end
            chk("one_gnt", {31'b0, bus.if_gnt & bus.ls_gnt}, 32'd0);
            chk("if_gnt_needs_req", {31'b0, bus.if_gnt & ~bus.if_req}, 32'd0);
            chk("ls_gnt_needs_req", {31'b0, bus.ls_gnt & ~bus.ls_req}, 32'd0);
            prev_if_gnt = bus.if_gnt;
            prev_ls_rd  = bus.ls_gnt & ~bus.ls_we & ~bus.ls_err;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bd_we = 1'b0; bd_addr = 8'h00; bd_data = 32'h0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b10;
        bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;

        // reset state with both requests high
        @(negedge clk);
        chk("rst_if_gnt",    {31'b0, bus.if_gnt},    32'd0);
        chk("rst_ls_gnt",    {31'b0, bus.ls_gnt},    32'd0);
        chk("rst_ls_err",    {31'b0, bus.ls_err},    32'd0);
        chk("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        chk("rst_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
        chk("rst_mem_we",    {31'b0, bus.mem_we},    32'd0);
        chk("rst_if_rdata",  bus.if_rdata,           32'd0);
        chk("rst_ls_rdata",  bus.ls_rdata,           32'd0);
        bus.if_req = 1'b0; bus.ls_req = 1'b0;

        // preload RAM: word i = 0xA500_00ii
        @(posedge clk); #1;
        bd_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bd_addr = i[7:0];
            bd_data = 32'hA500_0000 | i;
            tick();
        end
        bd_we = 1'b0;
        rst = 1'b1;
        tick();

        // IF-only streaming reads of words 0,1,2
        for (int i = 0; i < 3; i++) begin
            bus.if_req = 1'b1;
            bus.if_addr = 32'(i * 4);
            @(negedge clk);
            chk("if_stream_gnt", {31'b0, bus.if_gnt}, 32'd1);
            if (bus.if_gnt) if_q.push_back(32'hA500_0000 | i);
            tick();
        end
        bus.if_req = 1'b0;
        tick(); tick();

        // fresh reset, then contention: LS first, then alternate
        rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b10; bus.ls_addr = 32'h8;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("alt_ls_gnt", {31'b0, bus.ls_gnt}, {31'b0, (c % 2 == 0)});
            chk("alt_if_gnt", {31'b0, bus.if_gnt}, {31'b0, (c % 2 != 0)});
            if (bus.ls_gnt) ls_q.push_back(32'hA500_0002);
            if (bus.if_gnt) if_q.push_back(32'hA500_0000);
            tick();
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        tick(); tick();

        // load/store vector table
        add(1'b1, 2'b10, 32'h10,  32'h1122_3344, 1'b0, 32'h0);
        add(1'b0, 2'b10, 32'h10,  32'h0,         1'b0, 32'h1122_3344);
        add(1'b1, 2'b00, 32'h12,  32'h0000_00AB, 1'b0, 32'h0);
        add(1'b0, 2'b10, 32'h10,  32'h0,         1'b0, 32'h11AB_3344);
        add(1'b1, 2'b10, 32'h10,  32'h1122_3344, 1'b0, 32'h0);
        add(1'b1, 2'b01, 32'h12,  32'h0000_BEEF, 1'b0, 32'h0);
        add(1'b0, 2'b10, 32'h10,  32'h0,         1'b0, 32'hBEEF_3344);
        add(1'b1, 2'b01, 32'h13,  32'h0000_1234, 1'b1, 32'h0);
        add(1'b0, 2'b10, 32'h10,  32'h0,         1'b0, 32'hBEEF_3344);
        add(1'b1, 2'b10, 32'h20,  32'hFFFF_FFFF, 1'b0, 32'h0);
        add(1'b1, 2'b00, 32'h20,  32'h1234_5600, 1'b0, 32'h0);
        add(1'b1, 2'b00, 32'h23,  32'h0000_0077, 1'b0, 32'h0);
        add(1'b1, 2'b01, 32'h20,  32'hDEAD_CAFE, 1'b0, 32'h0);
        add(1'b0, 2'b10, 32'h20,  32'h0,         1'b0, 32'h77FF_CAFE);
        add(1'b0, 2'b00, 32'h13,  32'h0,         1'b0, 32'hBEEF_3344);
        add(1'b0, 2'b10, 32'h410, 32'h0,         1'b0, 32'hBEEF_3344);
        add(1'b1, 2'b10, 32'h22,  32'h0,         1'b1, 32'h0);
        add(1'b0, 2'b10, 32'h21,  32'h0,         1'b1, 32'h0);
        add(1'b0, 2'b01, 32'h11,  32'h0,         1'b1, 32'h0);
        add(1'b0, 2'b11, 32'h10,  32'h0,         1'b1, 32'h0);
        add(1'b1, 2'b11, 32'h10,  32'h0,         1'b1, 32'h0);
        add(1'b0, 2'b10, 32'h20,  32'h0,         1'b0, 32'h77FF_CAFE);
        add(1'b0, 2'b10, 32'h10,  32'h0,         1'b0, 32'hBEEF_3344);
        add(1'b1, 2'b01, 32'h22,  32'h0000_0102, 1'b0, 32'h0);
        add(1'b0, 2'b10, 32'h20,  32'h0,         1'b0, 32'h0102_CAFE);
        for (int k = 0; k < tbl.size(); k++) ls_op(tbl[k]);
        tick(); tick();

        // IF request arriving during a byte-store MERGE waits one cycle
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b00;
        bus.ls_addr = 32'h31; bus.ls_wdata = 32'h0000_00EE;
        @(negedge clk);
        chk("sb_grant", {31'b0, bus.ls_gnt}, 32'd1);
        tick();
        bus.ls_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        @(negedge clk);
        chk("merge_if_held",  {31'b0, bus.if_gnt}, 32'd0);
        chk("merge_mem_we",   {31'b0, bus.mem_we}, 32'd1);
        chk("merge_mem_addr", {24'b0, bus.mem_addr}, 32'd12);
        chk("merge_wdata",    bus.mem_wdata, 32'hA500_EE0C);
        tick();
        @(negedge clk);
        chk("after_merge_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
        if (bus.if_gnt) if_q.push_back(32'hA500_EE0C);
        tick();
        bus.if_req = 1'b0;
        tick(); tick();

        // reset asserted during MERGE aborts the write
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b00;
        bus.ls_addr = 32'h34; bus.ls_wdata = 32'h0000_0099;
        @(negedge clk);
        chk("rmw_grant", {31'b0, bus.ls_gnt}, 32'd1);
        @(posedge clk); #1;
        bus.ls_req = 1'b0;
        rst = 1'b0;
        if_q.delete(); ls_q.delete();
        @(negedge clk);
        chk("abort_mem_we",    {31'b0, bus.mem_we},    32'd0);
        chk("abort_ls_gnt",    {31'b0, bus.ls_gnt},    32'd0);
        chk("abort_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
        chk("abort_ls_rdata",  bus.ls_rdata,           32'd0);
        chk("abort_if_rdata",  bus.if_rdata,           32'd0);
        tick();
        rst = 1'b1;
        tick();
        begin
            vec_t v;
            v.we = 1'b0; v.sz = 2'b10; v.addr = 32'h34; v.wdata = 32'h0;
            v.err = 1'b0; v.rdata = 32'hA500_000D;
            ls_op(v);
        end
        tick(); tick(); tick();

        chk("if_q_drained", if_q.size(), 32'd0);
        chk("ls_q_drained", ls_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
